imem_loader: RTL and testbench

- Writer side of the instruction-fetch path: fills instruction memory with a program before the IF stage starts reading it.
- Takes a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Issues one single-cycle write per word into instruction memory.
- Holds the pipeline in reset until the programmed word count has been written, then releases it.

---
 rtl/imem_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_imem_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction-fetch path.
// Accepts a byte stream (valid/ready), packs big-endian 32-bit words, issues
// one single-cycle instruction-memory write per word, and holds the pipeline
// in reset (CpuRst_out=0) until the requested number of words is written.
//
// Optional build macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, one extra 4-byte trailer word follows the program. It is
//   compared against the modulo-2^32 sum of the written words. On a mismatch
//   ChkErr is raised and the CPU stays in reset.
//
// Handshake: a byte transfers on a rising edge where ByteValid && ByteReady.
// ByteReady depends only on state (high in COLLECT), never on ByteValid, so
// the producer may hold ByteValid high indefinitely without a loop.
module imem_loader #(
   parameter int          ADDR_WIDTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Start,
   input  logic [ADDR_WIDTH:0]   LenWords,
   input  logic [7:0]            ByteIn,
   input  logic                  ByteValid,
   output logic                  ByteReady,
   output logic                  MemWrite_out,
   output logic [31:0]           MemAddr_out,
   output logic [31:0]           MemData_out,
   output logic                  CpuRst_out,
   output logic                  Busy,
   output logic                  Done,
   output logic [ADDR_WIDTH:0]   WordCount,
   output logic                  ChkErr,
   output logic [1:0]            state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   // Capacity of the memory in words; longer requests are clamped to this.
   localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ONE_WORD  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                state_q;
   state_t                state_nxt;

   logic [ADDR_WIDTH:0]   len_words_q;
   logic [ADDR_WIDTH:0]   word_count_q;
   logic [1:0]            byte_idx_q;
   logic [23:0]           word_buf_q;
   logic [31:0]           mem_addr_q;
   logic [31:0]           mem_data_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic                  trailer_phase_q;
   logic [31:0]           sum_q;
   logic                  chk_err_q;
`endif

   logic                  start_ok;
   logic                  byte_xfer;
   logic                  last_byte;
   logic [ADDR_WIDTH:0]   count_inc;
   logic [ADDR_WIDTH:0]   clamped_len;
   logic                  final_write;
   logic [31:0]           word_addr;

   assign start_ok    = Start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign byte_xfer   = ByteValid && (state_q == S_COLLECT);
   assign last_byte   = byte_xfer && (byte_idx_q == 2'd3);
   assign count_inc   = word_count_q + ONE_WORD;
   assign clamped_len = (LenWords > MAX_WORDS) ? MAX_WORDS : LenWords;
   assign final_write = (count_inc == len_words_q);

   // Word index -> byte address. word_count never reaches MAX_WORDS while a
   // word is being collected, so the low ADDR_WIDTH bits are sufficient.
   assign word_addr = BASE_ADDR +
                      {{(30 - ADDR_WIDTH){1'b0}}, word_count_q[ADDR_WIDTH-1:0], 2'b00};

   // State register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_ok) begin
               if (clamped_len != '0) begin
                  state_nxt = S_COLLECT;
               end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  // An empty program still carries a trailer (must be 0).
                  state_nxt = S_COLLECT;
`else
                  state_nxt = S_DONE;
`endif
               end
            end
         end
         S_COLLECT: begin
            if (last_byte) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_nxt = trailer_phase_q ? S_DONE : S_WRITE;
`else
               state_nxt = S_WRITE;
`endif
            end
         end
         S_WRITE: begin
            if (final_write) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_nxt = S_COLLECT;
`else
               state_nxt = S_DONE;
`endif
            end else begin
               state_nxt = S_COLLECT;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Load bookkeeping: latched length, words written and byte position.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         len_words_q  <= '0;
         word_count_q <= '0;
         byte_idx_q   <= 2'd0;
      end else begin
         if (start_ok) begin
            len_words_q  <= clamped_len;
            word_count_q <= '0;
            byte_idx_q   <= 2'd0;
         end else begin
            if (byte_xfer) begin
               byte_idx_q <= byte_idx_q + 2'd1;
            end
            if (state_q == S_WRITE) begin
               word_count_q <= count_inc;
            end
         end
      end
   end

   // Word assembly, big-endian: byte 0 lands in bits [31:24]. The fourth
   // byte goes straight into the write register together with its address,
   // so the write cycle presents both and they hold until the next word.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         word_buf_q <= '0;
         mem_addr_q <= BASE_ADDR;
         mem_data_q <= '0;
      end else if (byte_xfer) begin
         case (byte_idx_q)
            2'd0: word_buf_q[23:16] <= ByteIn;
            2'd1: word_buf_q[15:8]  <= ByteIn;
            2'd2: word_buf_q[7:0]   <= ByteIn;
            default: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               if (!trailer_phase_q) begin
                  mem_data_q <= {word_buf_q, ByteIn};
                  mem_addr_q <= word_addr;
               end
`else
               mem_data_q <= {word_buf_q, ByteIn};
               mem_addr_q <= word_addr;
`endif
            end
         endcase
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   // Checksum: running sum of written words, trailer phase flag and result.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         trailer_phase_q <= 1'b0;
         sum_q           <= '0;
         chk_err_q       <= 1'b0;
      end else begin
         if (start_ok) begin
            trailer_phase_q <= (clamped_len == '0);
            sum_q           <= '0;
            chk_err_q       <= 1'b0;
         end else begin
            if (state_q == S_WRITE) begin
               sum_q <= sum_q + mem_data_q;
               if (final_write) begin
                  trailer_phase_q <= 1'b1;
               end
            end
            if (last_byte && trailer_phase_q) begin
               chk_err_q       <= ({word_buf_q, ByteIn} != sum_q);
               trailer_phase_q <= 1'b0;
            end
         end
      end
   end

   assign ChkErr     = chk_err_q;
   assign CpuRst_out = (state_q == S_DONE) && !chk_err_q;
`else
   assign ChkErr     = 1'b0;
   assign CpuRst_out = (state_q == S_DONE);
`endif

   // Status and strobe outputs decode directly from state.
   assign ByteReady    = (state_q == S_COLLECT);
   assign MemWrite_out = (state_q == S_WRITE);
   assign Busy         = (state_q == S_COLLECT) || (state_q == S_WRITE);
   assign Done         = (state_q == S_DONE);
   assign MemAddr_out  = mem_addr_q;
   assign MemData_out  = mem_data_q;
   assign WordCount    = word_count_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed loads, a queue-based write model and one
// compare process watching every write strobe.
module tb_imem_loader;

   localparam int          AW   = 8;
   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          CAP  = 1 << AW;

   logic          Clk;
   logic          Rst;
   logic          Start;
   logic [AW:0]   LenWords;
   logic [7:0]    ByteIn;
   logic          ByteValid;
   logic          ByteReady;
   logic          MemWrite_out;
   logic [31:0]   MemAddr_out;
   logic [31:0]   MemData_out;
   logic          CpuRst_out;
   logic          Busy;
   logic          Done;
   logic [AW:0]   WordCount;
   logic          ChkErr;
   logic [1:0]    state_dbg;

   imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .LenWords(LenWords),
      .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
      .MemWrite_out(MemWrite_out), .MemAddr_out(MemAddr_out),
      .MemData_out(MemData_out), .CpuRst_out(CpuRst_out), .Busy(Busy),
      .Done(Done), .WordCount(WordCount), .ChkErr(ChkErr),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------- scoreboard ----------------
   int          chk_cnt  = 0;
   int          pass_cnt = 0;
   logic [63:0] exp_q[$];          // {addr, data} of each expected write
   logic [7:0]  stim_q[$];         // byte stream for the current load
   logic [31:0] model_sum;
   logic [31:0] last_addr;
   logic [31:0] last_data;
   logic        prev_mw = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Model: the first min(len, capacity) words of the stream are written in
   // order, word i at BASE + 4*i, bytes packed most-significant first.
   task automatic model_words(input int len);
      int n;
      logic [31:0] w;
      n = (len > CAP) ? CAP : len;
      model_sum = 32'h0;
      for (int i = 0; i < n; i++) begin
         w = {stim_q[4*i], stim_q[4*i+1], stim_q[4*i+2], stim_q[4*i+3]};
         exp_q.push_back({BASE + 32'(4*i), w});
         model_sum = model_sum + w;
      end
   endtask

   // Compare process: every write strobe must match the next model entry
   // and be exactly one cycle wide.
   always @(negedge Clk) begin
      if (Rst && MemWrite_out) begin
         if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write",
                     MemAddr_out, MemData_out);
         end else begin
            chk("write_addr_data_hi", exp_q[0][63:32], MemAddr_out);
            chk("write_data", MemData_out, exp_q[0][31:0]);
            void'(exp_q.pop_front());
         end
         chk("write_width", {31'b0, prev_mw}, 32'd0);
         last_addr = MemAddr_out;
         last_data = MemData_out;
      end
      if (ByteReady) chk("ready_implies_busy", {31'b0, Busy}, 32'd1);
      prev_mw = MemWrite_out;
   end

   // ---------------- driver tasks ----------------
   // All tasks start and end 1 time unit after a rising edge.
   task automatic tick();
      @(posedge Clk); #1;
   endtask

   task automatic start_load(input int len);
      Start = 1'b1; LenWords = (AW+1)'(len);
      tick();
      Start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit got;
      int n;
      ByteIn = b; ByteValid = 1'b1; n = 0; got = 1'b0;
      while (!got && n < 40) begin
         @(negedge Clk);
         got = ByteReady;
         tick();
         n++;
      end
      if (!got) begin
         chk_cnt++;
         $display("FAIL byte_timeout: got no ready expected ready within 40 cycles");
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
   endtask

   task automatic send_stream(input int from, input int upto);
      for (int i = from; i < upto; i++) send_byte(stim_q[i]);
   endtask

   task automatic finish_trailer(input logic [31:0] t);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(t);
`endif
      ByteValid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!Done && n < 60) begin tick(); n++; end
      chk("done_reached", {31'b0, Done}, 32'd1);
   endtask

   task automatic pulse_reset();
      Rst = 1'b0; #2;
      Rst = 1'b1;
      tick();
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_ready"},   {31'b0, ByteReady},    32'd0);
      chk({tag, "_mw"},      {31'b0, MemWrite_out}, 32'd0);
      chk({tag, "_busy"},    {31'b0, Busy},         32'd0);
      chk({tag, "_done"},    {31'b0, Done},         32'd0);
      chk({tag, "_cpurst"},  {31'b0, CpuRst_out},   32'd0);
      chk({tag, "_chkerr"},  {31'b0, ChkErr},       32'd0);
      chk({tag, "_addr"},    MemAddr_out,           BASE);
      chk({tag, "_data"},    MemData_out,           32'd0);
      chk({tag, "_count"},   32'(WordCount),        32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      Rst = 1'b0; Start = 1'b0; LenWords = '0; ByteIn = '0; ByteValid = 1'b0;
      #3;
      check_reset_values("reset");
      tick(); tick();
      Rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("idle_cpurst", {31'b0, CpuRst_out}, 32'd0);
         chk("idle_busy",   {31'b0, Busy},       32'd0);
      end

      // Two-word load, back-to-back bytes.
      stim_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
      model_words(2);
      start_load(2);
      chk("t1_busy", {31'b0, Busy}, 32'd1);
      send_stream(0, 8);
      ByteValid = 1'b0;
      chk("t1_write_cycle", {31'b0, MemWrite_out}, 32'd1);
      chk("t1_cpurst_during_write", {31'b0, CpuRst_out}, 32'd0);
      tick();
`ifdef IMEM_LOADER_CHECKSUM_EN
      finish_trailer(model_sum);
      tick();
`else
      chk("t1_done_next", {31'b0, Done}, 32'd1);
      chk("t1_cpurst_next", {31'b0, CpuRst_out}, 32'd1);
`endif
      chk("t1_count", 32'(WordCount), 32'd2);
      chk("t1_last_data", last_data, 32'h8C09_0004);
      chk("t1_last_addr", last_addr, 32'h0000_0004);
      chk("t1_hold_data", MemData_out, 32'h8C09_0004);
      chk("t1_all_written", exp_q.size(), 32'd0);

      // Stalled stream: ByteValid low for 7 cycles after byte 2.
      stim_q = '{8'h12, 8'h34, 8'h56, 8'h78};
      model_words(1);
      start_load(1);
      send_stream(0, 2);
      ByteValid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("stall_no_write", {31'b0, MemWrite_out}, 32'd0);
         chk("stall_busy", {31'b0, Busy}, 32'd1);
      end
      send_stream(2, 4);
      finish_trailer(model_sum);
      wait_done();
      chk("stall_word", last_data, 32'h1234_5678);
      chk("stall_all_written", exp_q.size(), 32'd0);

      // Start during COLLECT is ignored.
      stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
      model_words(2);
      start_load(2);
      send_stream(0, 2);
      ByteValid = 1'b0;
      start_load(1);
      chk("busy_start_count", 32'(WordCount), 32'd0);
      send_stream(2, 8);
      finish_trailer(model_sum);
      wait_done();
      chk("busy_start_words", 32'(WordCount), 32'd2);
      chk("busy_start_all", exp_q.size(), 32'd0);

      // Reset after 6 bytes of a 3-word load: only word 0 is written.
      stim_q = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00, 8'h22,
                 8'h00, 8'h00, 8'h00, 8'h33};
      model_words(1);
      start_load(3);
      send_stream(0, 6);
      ByteValid = 1'b0;
      chk("midrst_first_written", exp_q.size(), 32'd0);
      Rst = 1'b0; #2;
      check_reset_values("midrst");
      tick();
      Rst = 1'b1;
      tick();
      model_words(3);
      start_load(3);
      send_stream(0, 12);
      finish_trailer(model_sum);
      wait_done();
      chk("midrst_last_addr", last_addr, 32'h0000_0008);
      chk("midrst_all", exp_q.size(), 32'd0);

      // LenWords=0 from IDLE: no writes.
      pulse_reset();
      stim_q.delete();
      model_words(0);
      start_load(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      finish_trailer(32'h0);
`else
      chk("len0_done_next", {31'b0, Done}, 32'd1);
`endif
      wait_done();
      chk("len0_count", 32'(WordCount), 32'd0);
      chk("len0_cpurst", {31'b0, CpuRst_out}, 32'd1);

      // Oversized length clamps to memory capacity.
      stim_q.delete();
      for (int i = 0; i < CAP; i++) begin
         logic [7:0] ib;
         ib = i[7:0];
         stim_q.push_back(8'hA5); stim_q.push_back(ib);
         stim_q.push_back(~ib);   stim_q.push_back(8'h3C);
      end
      model_words(300);
      start_load(300);
      send_stream(0, 4*CAP);
      finish_trailer(model_sum);
      wait_done();
      chk("clamp_count", 32'(WordCount), 32'd256);
      chk("clamp_last_addr", last_addr, 32'h0000_03FC);
      chk("clamp_last_data", last_data, 32'hA5FF_003C);
      chk("clamp_all", exp_q.size(), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum match and mismatch with words 1, 2.
      stim_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
      model_words(2);
      start_load(2);
      send_stream(0, 8);
      finish_trailer(32'h0000_0003);
      wait_done();
      chk("csum_ok_cpurst", {31'b0, CpuRst_out}, 32'd1);
      chk("csum_ok_err", {31'b0, ChkErr}, 32'd0);
      model_words(2);
      start_load(2);
      send_stream(0, 8);
      finish_trailer(32'h0000_0004);
      wait_done();
      chk("csum_bad_err", {31'b0, ChkErr}, 32'd1);
      chk("csum_bad_cpurst", {31'b0, CpuRst_out}, 32'd0);
`else
      chk("no_csum_err", {31'b0, ChkErr}, 32'd0);
`endif

      tick(); tick();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
